datapath_issue: RTL

Instruction issue sequencer that drives the control and register-select inputs of `datapath`. It accepts 24-bit instruction words over a valid/ready handshake and expands each word into one or more per-cycle datapath beats, incrementing register indices per vector lane. It inserts a one-cycle bubble on read-after-write hazards and suppresses writes to the zero register. It sits between the instruction source and `datapath`, and all of its outputs connect port-for-port to `datapath`.

---
 rtl/datapath_issue.sv | 118 +++++++++++
 1 files changed

// File: rtl/datapath_issue.sv
// Instruction issue sequencer for datapath: expands each 24-bit word into vec+1 beats,
// inserts a bubble on read-after-write hazards, and suppresses zero-register writes.
module datapath_issue #(
  parameter logic [3:0] ZERO_REG = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_instr,
  input  logic        hold,
  output logic [2:0]  op,
  output logic        form,
  output logic [1:0]  vec,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  zero_reg,
  output logic [1:0]  write,
  output logic        issue_valid,
  output logic        busy
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e      state_q;
  logic [23:0] instr_q;
  logic [1:0]  k_q;

  logic        last_beat;
  logic        accept;
  logic        load;
  logic        go_idle;
  logic [23:0] src_word;
  logic [1:0]  src_k;
  logic [3:0]  a_n, b_n, c_n, d_n;
  logic [1:0]  w_eff;
  logic        hazard;

  assign zero_reg  = ZERO_REG;
  assign busy      = (state_q == StIssue);
  // The displayed beat is the last one and is a real issue (not a bubble).
  assign last_beat = issue_valid && (k_q == instr_q[19:18]);
  assign in_ready  = !hold && ((state_q == StIdle) || ((state_q == StIssue) && last_beat));
  assign accept    = in_ready && in_valid;

  always_comb begin
    src_word = instr_q;
    src_k    = k_q;
    load     = 1'b0;
    go_idle  = 1'b0;
    if (accept) begin
      src_word = in_instr;
      src_k    = 2'd0;
      load     = 1'b1;
    end else if (state_q == StIssue) begin
      if (!issue_valid) begin
        // Bubble shown: re-present the same beat, now as a real issue.
        load = 1'b1;
      end else if (!last_beat) begin
        src_k = k_q + 2'd1;
        load  = 1'b1;
      end else begin
        go_idle = 1'b1;
      end
    end
  end

  always_comb begin
    a_n   = src_word[17:14] + {2'b00, src_k};
    b_n   = src_word[13:10] + {2'b00, src_k};
    c_n   = src_word[9:6]   + {2'b00, src_k};
    d_n   = src_word[5:2]   + {2'b00, src_k};
    w_eff = {src_word[1] && (d_n != ZERO_REG), src_word[0] && (c_n != ZERO_REG)};
    // History is the currently displayed cycle; a bubble carries write=00, valid=0.
    hazard = issue_valid &&
             ((write[0] && ((C == a_n) || (C == b_n))) ||
              (write[1] && ((D == a_n) || (D == b_n))));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      k_q         <= '0;
      op          <= '0;
      form        <= 1'b0;
      vec         <= '0;
      A           <= '0;
      B           <= '0;
      C           <= '0;
      D           <= '0;
      write       <= '0;
      issue_valid <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        state_q     <= StIssue;
        instr_q     <= src_word;
        k_q         <= src_k;
        op          <= src_word[23:21];
        form        <= src_word[20];
        vec         <= src_k;
        A           <= a_n;
        B           <= b_n;
        C           <= c_n;
        D           <= d_n;
        write       <= hazard ? 2'b00 : w_eff;
        issue_valid <= !hazard;
      end else if (go_idle) begin
        state_q     <= StIdle;
        write       <= 2'b00;
        issue_valid <= 1'b0;
      end
    end
  end

endmodule
